// File: rtl/ftdi_tx_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_tx_engine_if
// Summary  : FIFO read port and FT245 synchronous write bus bundle for ftdi_tx_engine.
// Revision : 1.0 - initial release
// ============================================================================
interface ftdi_tx_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_enable;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  ftdi_txe_n;
    logic                  ftdi_wr_n;
    logic [DATA_WIDTH-1:0] ftdi_data;
    logic                  ftdi_data_oe;
    logic                  ftdi_siwu_n;
    logic [15:0]           tx_byte_cnt;

    // Engine side
    modport slave (
        input  tx_enable, fifo_empty, fifo_rd_data, ftdi_txe_n,
        output fifo_rd_en, ftdi_wr_n, ftdi_data, ftdi_data_oe, ftdi_siwu_n, tx_byte_cnt
    );

    // Environment side: FIFO, FTDI device and control
    modport master (
        output tx_enable, fifo_empty, fifo_rd_data, ftdi_txe_n,
        input  fifo_rd_en, ftdi_wr_n, ftdi_data, ftdi_data_oe, ftdi_siwu_n, tx_byte_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ftdi_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_tx_engine
// Summary  : Drains the TX FIFO onto the FT245 synchronous write bus through a
//            2-entry holding buffer; optional send-immediate pulse when
//            FTDI_SEND_IMMEDIATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ftdi_tx_engine #(
    parameter int DATA_WIDTH       = 8,
    parameter int SIWU_IDLE_CYCLES = 64
) (
    input  wire             clk,
    input  wire             async_rst_n,
    ftdi_tx_engine_if.slave tx_if
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    if (SIWU_IDLE_CYCLES < 1) begin : g_siwu_cfg_check
        $error("SIWU_IDLE_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  wr_n_q, wr_n_d;
    logic                  oe_q, oe_d;
    logic [15:0]           cnt_q, cnt_d;

    logic                  pop;
    logic                  rd_en;
    logic [2:0]            pending;
    logic [1:0]            occ_popped;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISABLED: if (tx_if.tx_enable) state_d = ST_ACTIVE;
            ST_ACTIVE:   if (!tx_if.tx_enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (tx_if.tx_enable)
                    state_d = ST_ACTIVE;
                else if (occ_q == 2'd0 && !inflight_q)
                    state_d = ST_DISABLED;
            end
            default:     state_d = ST_DISABLED;
        endcase
        oe_d = (state_d != ST_DISABLED);
    end

    always_comb begin
        pop        = ~wr_n_q & ~tx_if.ftdi_txe_n;
        pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en      = (state_q == ST_ACTIVE) & ~tx_if.fifo_empty & (pending < 3'd2);
        occ_popped = occ_q - {1'b0, pop};

        data_d = data_q;
        skid_d = skid_q;
        if (pop && occ_q == 2'd2)
            data_d = skid_q;
        // Returning read data fills the lowest entry left free after the pop
        if (inflight_q) begin
            if (occ_popped == 2'd0)
                data_d = tx_if.fifo_rd_data;
            else
                skid_d = tx_if.fifo_rd_data;
        end

        occ_d      = occ_popped + {1'b0, inflight_q};
        inflight_d = rd_en;
        wr_n_d     = (occ_d == 2'd0);
        cnt_d      = cnt_q + {15'd0, pop};
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q    <= ST_DISABLED;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            data_q     <= '0;
            skid_q     <= '0;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            data_q     <= data_d;
            skid_q     <= skid_d;
            wr_n_q     <= wr_n_d;
            oe_q       <= oe_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_if.fifo_rd_en   = rd_en;
    assign tx_if.ftdi_wr_n    = wr_n_q;
    assign tx_if.ftdi_data    = data_q;
    assign tx_if.ftdi_data_oe = oe_q;
    assign tx_if.tx_byte_cnt  = cnt_q;

`ifdef FTDI_SEND_IMMEDIATE_EN
    localparam logic [15:0] C_SIWU_LIMIT = 16'(SIWU_IDLE_CYCLES);

    logic [15:0] idle_q, idle_d;
    logic        sent_q, sent_d;
    logic        siwu_n_q, siwu_n_d;
    logic        idle_cond;

    // Idle time only counts once something has gone out since the last pulse
    always_comb begin
        idle_cond = (state_q == ST_ACTIVE) && (occ_q == 2'd0) && !inflight_q &&
                    tx_if.fifo_empty && sent_q;
        idle_d    = idle_q;
        sent_d    = sent_q | pop;
        siwu_n_d  = 1'b1;
        if (pop || rd_en) begin
            idle_d = 16'd0;
        end else if (idle_cond) begin
            if (idle_q + 16'd1 == C_SIWU_LIMIT) begin
                idle_d   = 16'd0;
                sent_d   = 1'b0;
                siwu_n_d = 1'b0;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            idle_q   <= 16'd0;
            sent_q   <= 1'b0;
            siwu_n_q <= 1'b1;
        end else begin
            idle_q   <= idle_d;
            sent_q   <= sent_d;
            siwu_n_q <= siwu_n_d;
        end
    end

    assign tx_if.ftdi_siwu_n = siwu_n_q;
`else
    assign tx_if.ftdi_siwu_n = 1'b1;
`endif

endmodule
`default_nettype wire
